// File: rtl/elastic_fifo.sv
// elastic_fifo: DEPTH-entry ready/valid elastic buffer with synchronous flush; 1-cycle latency, ready_in never depends on ready_out.
// Define ELASTIC_FIFO_BYPASS_EN to forward data_in straight to data_out while the buffer is empty (zero latency).
module elastic_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  push;
  logic                  pop;
  logic                  write;
  logic                  bypass;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign ready_in = !full && !flush && reset;
  assign push     = valid_in && ready_in;

`ifdef ELASTIC_FIFO_BYPASS_EN
  assign bypass = empty && valid_in && !flush && reset;
`else
  assign bypass = 1'b0;
`endif

  assign valid_out = (!empty && !flush) || bypass;
  assign data_out  = bypass ? data_in : mem[rd_ptr];

  // pop covers stored entries only; a bypassed item taken this cycle is simply never written.
  assign pop   = !empty && !flush && ready_out;
  assign write = push && !(bypass && ready_out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      case ({write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_elastic_fifo.sv
// Directed and scoreboard-driven checks of elastic_fifo at DEPTH=4 and DEPTH=3.
module tb_elastic_fifo;

`ifdef ELASTIC_FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // DEPTH = 4 instance
  logic       flush = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
  logic [7:0] data_in = '0;
  logic       ready_in, valid_out, full, empty;
  logic [7:0] data_out;
  logic [2:0] count;

  // DEPTH = 3 instance
  logic       flush3 = 1'b0, valid_in3 = 1'b0, ready_out3 = 1'b0;
  logic [7:0] data_in3 = '0;
  logic       ready_in3, valid_out3, full3, empty3;
  logic [7:0] data_out3;
  logic [1:0] count3;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_d;
  logic       exp_v;
  logic [2:0] exp_c;

  elastic_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .count(count), .full(full), .empty(empty)
  );

  elastic_fifo #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush3),
    .valid_in(valid_in3), .ready_in(ready_in3), .data_in(data_in3),
    .valid_out(valid_out3), .ready_out(ready_out3), .data_out(data_out3),
    .count(count3), .full(full3), .empty(empty3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    step();
    step();
    #3;
    n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out); else n_pass++;
    n_total++; if (ready_in !== 1'b0) $display("FAIL reset_ready_in got %b want 0", ready_in); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_total++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else n_pass++;
    step();
    reset = 1'b1;
    #3;
    n_total++; if (ready_in !== 1'b1) $display("FAIL release_ready_in got %b want 1", ready_in); else n_pass++;
    n_total++; if (ready_in3 !== 1'b1) $display("FAIL release_ready_in3 got %b want 1", ready_in3); else n_pass++;
  endtask

  task automatic test_streaming();
    ready_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      valid_in = 1'b1;
      data_in = 8'(i);
      #3;
      n_total++; if (ready_in !== 1'b1) $display("FAIL stream_ready_in[%0d] got %b want 1", i, ready_in); else n_pass++;
      exp_v = BYPASS || (i > 0);
      n_total++; if (valid_out !== exp_v) $display("FAIL stream_valid_out[%0d] got %b want %b", i, valid_out, exp_v); else n_pass++;
      if (exp_v) begin
        exp_d = BYPASS ? 8'(i) : 8'(i - 1);
        n_total++; if (data_out !== exp_d) $display("FAIL stream_data_out[%0d] got %h want %h", i, data_out, exp_d); else n_pass++;
      end
      exp_c = (BYPASS || i == 0) ? 3'd0 : 3'd1;
      n_total++; if (count !== exp_c) $display("FAIL stream_count[%0d] got %0d want %0d", i, count, exp_c); else n_pass++;
    end
    step();
    valid_in = 1'b0;
    #3;
    exp_v = !BYPASS;
    n_total++; if (valid_out !== exp_v) $display("FAIL stream_tail_valid got %b want %b", valid_out, exp_v); else n_pass++;
    if (exp_v) begin
      n_total++; if (data_out !== 8'h09) $display("FAIL stream_tail_data got %h want 09", data_out); else n_pass++;
    end
    step();
    #3;
    n_total++; if (empty !== 1'b1) $display("FAIL stream_drained_empty got %b want 1", empty); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL stream_drained_valid got %b want 0", valid_out); else n_pass++;
  endtask

  task automatic test_fill_stall();
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      valid_in = 1'b1;
      data_in = 8'hA0 + 8'(i);
      #3;
      n_total++; if (ready_in !== 1'b1) $display("FAIL fill_ready_in[%0d] got %b want 1", i, ready_in); else n_pass++;
      n_total++; if (count !== 3'(i)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); else n_pass++;
    end
    step();
    data_in = 8'hA4;
    #3;
    n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else n_pass++;
    n_total++; if (ready_in !== 1'b0) $display("FAIL full_ready_in got %b want 0", ready_in); else n_pass++;
    n_total++; if (data_out !== 8'hA0) $display("FAIL full_head got %h want a0", data_out); else n_pass++;
    step();
    ready_out = 1'b1;
    #3;
    n_total++; if (ready_in !== 1'b0) $display("FAIL full_pop_ready_in got %b want 0", ready_in); else n_pass++;
    n_total++; if (data_out !== 8'hA0) $display("FAIL full_pop_data got %h want a0", data_out); else n_pass++;
    step();
    #3;
    n_total++; if (count !== 3'd3) $display("FAIL after_pop_count got %0d want 3", count); else n_pass++;
    n_total++; if (ready_in !== 1'b1) $display("FAIL after_pop_ready_in got %b want 1", ready_in); else n_pass++;
    n_total++; if (data_out !== 8'hA1) $display("FAIL after_pop_data got %h want a1", data_out); else n_pass++;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      exp_d = 8'hA2 + 8'(i);
      exp_c = 3'(3 - i);
      n_total++; if (data_out !== exp_d) $display("FAIL drain_data[%0d] got %h want %h", i, data_out, exp_d); else n_pass++;
      n_total++; if (count !== exp_c) $display("FAIL drain_count[%0d] got %0d want %0d", i, count, exp_c); else n_pass++;
      n_total++; if (valid_out !== 1'b1) $display("FAIL drain_valid[%0d] got %b want 1", i, valid_out); else n_pass++;
      step();
    end
    ready_out = 1'b0;
    #3;
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL drain_valid_end got %b want 0", valid_out); else n_pass++;
  endtask

  task automatic test_flush();
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      valid_in = 1'b1;
      data_in = 8'h11 + 8'(i);
    end
    step();
    flush = 1'b1;
    data_in = 8'hFF;
    #3;
    n_total++; if (valid_out !== 1'b0) $display("FAIL flush_valid_out got %b want 0", valid_out); else n_pass++;
    n_total++; if (ready_in !== 1'b0) $display("FAIL flush_ready_in got %b want 0", ready_in); else n_pass++;
    n_total++; if (count !== 3'd3) $display("FAIL flush_cycle_count got %0d want 3", count); else n_pass++;
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    #3;
    n_total++; if (count !== 3'd0) $display("FAIL post_flush_count got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL post_flush_empty got %b want 1", empty); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL post_flush_valid got %b want 0", valid_out); else n_pass++;
    step();
    valid_in = 1'b1;
    data_in = 8'h55;
    #3;
    n_total++; if (valid_out !== BYPASS) $display("FAIL push55_valid got %b want %b", valid_out, BYPASS); else n_pass++;
    step();
    valid_in = 1'b0;
    ready_out = 1'b1;
    #3;
    n_total++; if (valid_out !== 1'b1) $display("FAIL out55_valid got %b want 1", valid_out); else n_pass++;
    n_total++; if (data_out !== 8'h55) $display("FAIL out55_data got %h want 55", data_out); else n_pass++;
    step();
    ready_out = 1'b0;
    #3;
    n_total++; if (empty !== 1'b1) $display("FAIL out55_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_async_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      valid_in = 1'b1;
      data_in = 8'h70 + 8'(i);
    end
    step();
    valid_in = 1'b0;
    #3;
    n_total++; if (count !== 3'd2) $display("FAIL pre_areset_count got %0d want 2", count); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++; if (count !== 3'd0) $display("FAIL areset_count got %0d want 0", count); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL areset_valid got %b want 0", valid_out); else n_pass++;
    n_total++; if (ready_in !== 1'b0) $display("FAIL areset_ready_in got %b want 0", ready_in); else n_pass++;
    n_total++; if (data_out !== 8'h00) $display("FAIL areset_data got %h want 00", data_out); else n_pass++;
    step();
    reset = 1'b1;
    #3;
    n_total++; if (ready_in !== 1'b1) $display("FAIL areset_release_ready got %b want 1", ready_in); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL areset_release_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_wrap_around();
    logic [7:0] q[$];
    logic       hold = 1'b0;
    logic       e_rdy, e_vld, bypassed;
    int         sz;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (!hold) begin
        valid_in3 = ($urandom_range(0, 9) < 7);
        data_in3 = 8'($urandom);
      end
      ready_out3 = ($urandom_range(0, 9) < 4);
      #3;
      sz = q.size();
      e_rdy = (sz < 3);
      e_vld = (sz > 0) || (BYPASS && valid_in3);
      n_total++; if (count3 !== 2'(sz)) $display("FAIL wrap_count[%0d] got %0d want %0d", cyc, count3, sz); else n_pass++;
      n_total++; if (ready_in3 !== e_rdy) $display("FAIL wrap_ready_in[%0d] got %b want %b", cyc, ready_in3, e_rdy); else n_pass++;
      n_total++; if (valid_out3 !== e_vld) $display("FAIL wrap_valid[%0d] got %b want %b", cyc, valid_out3, e_vld); else n_pass++;
      if (e_vld) begin
        exp_d = (sz > 0) ? q[0] : data_in3;
        n_total++; if (data_out3 !== exp_d) $display("FAIL wrap_data[%0d] got %h want %h", cyc, data_out3, exp_d); else n_pass++;
      end
      bypassed = BYPASS && (sz == 0) && valid_in3 && ready_out3;
      if (e_vld && ready_out3 && sz > 0) void'(q.pop_front());
      if (valid_in3 && e_rdy && !bypassed) q.push_back(data_in3);
      hold = valid_in3 && !e_rdy;
    end
    step();
    valid_in3 = 1'b0;
    ready_out3 = 1'b0;
  endtask

  task automatic test_fuzz();
    logic [7:0] q[$];
    logic       hold = 1'b0;
    logic       e_rdy, e_vld, bypassed;
    int         sz;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      step();
      if (!hold) begin
        valid_in = ($urandom_range(0, 99) < 60);
        data_in = 8'($urandom);
      end
      ready_out = ($urandom_range(0, 99) < 50);
      flush = ($urandom_range(0, 99) < 2);
      #3;
      sz = q.size();
      e_rdy = (sz < 4) && !flush;
      e_vld = ((sz > 0) || (BYPASS && valid_in)) && !flush;
      n_total++; if (count !== 3'(sz)) $display("FAIL fuzz_count[%0d] got %0d want %0d", cyc, count, sz); else n_pass++;
      n_total++; if (ready_in !== e_rdy) $display("FAIL fuzz_ready_in[%0d] got %b want %b", cyc, ready_in, e_rdy); else n_pass++;
      n_total++; if (valid_out !== e_vld) $display("FAIL fuzz_valid[%0d] got %b want %b", cyc, valid_out, e_vld); else n_pass++;
      if (e_vld) begin
        exp_d = (sz > 0) ? q[0] : data_in;
        n_total++; if (data_out !== exp_d) $display("FAIL fuzz_data[%0d] got %h want %h", cyc, data_out, exp_d); else n_pass++;
      end
      if (flush) begin
        q.delete();
      end else begin
        bypassed = BYPASS && (sz == 0) && valid_in && ready_out;
        if (e_vld && ready_out && sz > 0) void'(q.pop_front());
        if (valid_in && e_rdy && !bypassed) q.push_back(data_in);
      end
      hold = valid_in && !e_rdy;
    end
    step();
    valid_in = 1'b0;
    ready_out = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_stall();
    test_flush();
    test_async_reset();
    test_wrap_around();
    test_fuzz();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
